// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a multi-cycle RV32I datapath. It sequences
// fetch/decode/execute/memory/writeback over one shared ALU and one memory port.
module multicycle_control_unit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_LATENCY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [2:0] MemSize,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_LUI    = 4'd8;
    localparam logic [3:0] S_AUIPC  = 4'd9;
    localparam logic [3:0] S_ALUWB  = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JALR1  = 4'd13;
    localparam logic [3:0] S_JALR2  = 4'd14;
    localparam logic [3:0] S_TRAP   = 4'd15;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_PASS = 4'h2;
    localparam logic [3:0] ALU_SLTU = 4'h3;
    localparam logic [3:0] ALU_SLT  = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_AND  = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic          w_in_mem;
    logic          w_mem_ok;
    logic          w_alt;
    logic          w_r_ok;
    logic          w_i_ok;
    logic          w_taken;
    logic [3:0]    w_arith_alu;
    logic [3:0]    w_branch_alu;

    assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : (r_cnt == CW'(MEM_LATENCY - 1));

    // funct7 = 0100000 is the only non-zero encoding that selects an alternate op.
    assign w_alt  = (funct7 == 7'b0100000);
    assign w_r_ok = (funct7 == 7'd0) || w_alt;
    assign w_i_ok = (funct3 == 3'b001) ? (funct7 == 7'd0) :
                    (funct3 == 3'b101) ? w_r_ok : 1'b1;

    assign w_branch_alu = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
    assign w_taken      = Zero ^ funct3[2] ^ funct3[0];

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_arith_alu = ALU_ADD;
        case (funct3)
            3'b000:  w_arith_alu = (opcode == OPC_OP && w_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  w_arith_alu = ALU_SLL;
            3'b010:  w_arith_alu = ALU_SLT;
            3'b011:  w_arith_alu = ALU_SLTU;
            3'b100:  w_arith_alu = ALU_XOR;
            3'b101:  w_arith_alu = w_alt ? ALU_SRA : ALU_SRL;
            3'b110:  w_arith_alu = ALU_OR;
            default: w_arith_alu = ALU_AND;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (w_mem_ok) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD:   w_next = (funct3 == 3'b011 || funct3[2:1] == 2'b11) ? S_TRAP : S_MEMADR;
                    OPC_STORE:  w_next = (funct3[2] || funct3 == 3'b011) ? S_TRAP : S_MEMADR;
                    OPC_OP:     w_next = S_EXECR;
                    OPC_OPIMM:  w_next = S_EXECI;
                    OPC_LUI:    w_next = S_LUI;
                    OPC_AUIPC:  w_next = S_AUIPC;
                    OPC_BRANCH: w_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OPC_JAL:    w_next = S_JAL;
                    OPC_JALR:   w_next = (funct3 != 3'b000) ? S_TRAP : S_JALR1;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (w_mem_ok) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (w_mem_ok) w_next = S_FETCH;
            S_EXECR:  w_next = w_r_ok ? S_ALUWB : S_TRAP;
            S_EXECI:  w_next = w_i_ok ? S_ALUWB : S_TRAP;
            S_LUI:    w_next = S_ALUWB;
            S_AUIPC:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JAL:    w_next = S_ALUWB;
            S_JALR1:  w_next = S_JALR2;
            S_JALR2:  w_next = S_ALUWB;
            default:  w_next = S_TRAP;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemSize    = 3'b000;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_mem_ok;
                PCWrite   = w_mem_ok;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OPC_JAL) ? 3'b100 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OPC_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                MemSize = funct3;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                MemSize  = funct3;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_arith_alu;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_arith_alu;
            end
            S_LUI: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b011;
                ALUControl = ALU_PASS;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b011;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_branch_alu;
                PCWrite    = w_taken;
            end
            S_JAL, S_JALR2: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            default: Illegal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // The wait counter only runs while a memory access is outstanding.
            if (w_in_mem && !w_mem_ok) r_cnt <= r_cnt + CW'(1);
            else                       r_cnt <= '0;
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I decoder.
- A Moore-style FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Supports full RV32I loads, stores and branches, plus LUI, AUIPC, JAL and JALR, with memory wait states.
- Flags illegal instructions with a sticky trap. Sits between the instruction register and the shared multi-cycle datapath.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory access completes on mem_ready; 0 = fixed latency, mem_ready ignored.
- MEM_LATENCY, 1, cycles per memory access when MEM_HANDSHAKE=0 (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- Zero  in  1  ALU zero flag, current cycle
- mem_ready  in  1  memory access complete (handshake mode)
- PCWrite  out  1  load PC from Result
- IRWrite  out  1  load IR and OldPC
- AdrSrc  out  1  0 = PC, 1 = ALUOut, as memory address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemSize  out  3  funct3 passthrough during MEMRD/MEMWR, else 0
- RegWrite  out  1  register-file write
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- ALUSrcB  out  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ALUControl  out  4  ADD=0, SUB=1, PASS_B=2, SLTU=3, SLT=4, XOR=5, OR=6, AND=7, SLL=8, SRL=9, SRA=A
- Illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset: rst high on a clock edge sets state=FETCH, wait counter=0, Illegal=0. Reset wins over every other event, including mid-access. While in FETCH after reset, outputs are the FETCH values.
- Unlisted outputs in each state default to 0 / ADD / ImmSrc 000.
- mem_ok: equals mem_ready when MEM_HANDSHAKE=1. When MEM_HANDSHAKE=0, equals (cnt==MEM_LATENCY-1). cnt increments only in FETCH/MEMRD/MEMWR and clears on leaving those states.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=mem_ok. Stay until mem_ok, then DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD, ImmSrc=100 if JAL else 010 (ALUOut = OldPC+imm).
- DECODE next state by opcode:
  - LOAD (funct3 ∈ {0,1,2,4,5}) → MEMADR
  - STORE (funct3 ∈ {0,1,2}) → MEMADR
  - OP → EXECR; OP_IMM → EXECI; LUI → LUI; AUIPC (0010111) → AUIPC
  - BRANCH (funct3 ≠ 2,3) → BRANCH; JAL → JAL; JALR (funct3=0) → JALR1
  - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD, ImmSrc=000 for load / 001 for store → MEMRD (load) or MEMWR (store).
- MEMRD: AdrSrc=1, MemRead=1, MemSize=funct3. Hold until mem_ok → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWR: AdrSrc=1, MemWrite=1, MemSize=funct3. Strobe is held until mem_ok → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. ALUControl decoded as in the single-cycle unit (funct7=0100000 selects SUB/SRA). Other funct7 values ≠ 0 → TRAP, otherwise → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. Shift-immediate funct7 rules are the same as for OP; violation → TRAP, otherwise → ALUWB.
- LUI: ALUSrcB=01, ImmSrc=011, PASS_B → ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=011, ADD → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00 → FETCH.
  - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - taken = Zero for BEQ/BGE/BGEU, !Zero for BNE/BLT/BLTU.
  - PCWrite=taken.
- JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ADD → ALUWB (rd = OldPC+4).
- JALR1: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ADD → JALR2.
- JALR2: ResultSrc=00, PCWrite=1 (datapath clears bit 0), ALUSrcA=01, ALUSrcB=10, ADD → ALUWB.
- TRAP: Illegal=1, all strobes 0. Remain in TRAP until rst.
- Cycle counts at zero wait: R/I/U = 4, load = 5, store = 4, branch = 3, JAL = 4, JALR = 5. Each memory wait adds 1 cycle.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH, DECODE, EXECR (ALUControl=0), ALUWB (RegWrite=1), 4 cycles, back to FETCH.
- lw, MEM_HANDSHAKE=1, mem_ready low 3 cycles in MEMRD → MemRead and AdrSrc=1 held 4 cycles, MemSize=010, then MEMWB RegWrite=1 with ResultSrc=01.
- bltu funct3=110 with Zero=0 → PCWrite=1 in BRANCH; repeat with Zero=1 → PCWrite=0; 3 cycles each.
- jalr → JALR1 then JALR2 (PCWrite=1) then ALUWB (RegWrite=1, ResultSrc=00).
- opcode 0x7F, then funct7=0x01 on OP → TRAP, Illegal=1 sticky for 10 cycles; rst → FETCH, Illegal=0.
- MEM_HANDSHAKE=0, MEM_LATENCY=3, sw → MemWrite high exactly 3 cycles; rst asserted mid-MEMWR → next cycle FETCH, MemWrite=0.
